// File: rtl/stp_watch_ctrl.sv
// stp_watch_ctrl: stopwatch control with start/stop/clear buttons, prescaled
// one-second tick, mm:ss counters and an hour-carry pulse.
// Optional lap capture is built when the macro STP_LAP_CAPTURE_EN is defined.
module stp_watch_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic       count_up_hr,
  output logic       rst_counters,
  output logic       running
`ifdef STP_LAP_CAPTURE_EN
  ,
  input  logic       btn_lap,
  output logic [5:0] lap_sec,
  output logic [5:0] lap_min,
  output logic       lap_valid
`endif
);

  localparam int unsigned PW = 26;
  localparam int unsigned CW = 6;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(59);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_start_q;
  logic            r_clear_q;
  logic [PW-1:0]   r_presc;
  logic [CW-1:0]   r_sec;
  logic [CW-1:0]   r_min;
  logic            r_count_up_hr;
  logic            r_rst_counters;
  logic            r_running;
  logic            w_start_ev;
  logic            w_clear_ev;
  logic            w_do_clear;
  logic            w_tick;

  assign w_start_ev = btn_start_stop & ~r_start_q;
  assign w_clear_ev = btn_clear & ~r_clear_q;
  assign w_tick     = (r_state == S_RUN) && (r_presc == TICK_LAST);

  assign sec          = r_sec;
  assign min          = r_min;
  assign count_up_hr  = r_count_up_hr;
  assign rst_counters = r_rst_counters;
  assign running      = r_running;

  // One registered copy per button for rising-edge detection
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
      r_clear_q <= 1'b0;
    end else begin
      r_start_q <= btn_start_stop;
      r_clear_q <= btn_clear;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; clear beats start outside RUN, start beats clear in RUN
  always_comb begin
    w_state_nxt = r_state;
    w_do_clear  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_clear_ev)      w_do_clear  = 1'b1;
        else if (w_start_ev) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_start_ev) w_state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (w_clear_ev) begin
          w_do_clear  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_start_ev) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Prescaler and mm:ss counters; counting keys off the current state so a
  // tick on the edge that enters PAUSE is still applied
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_sec   <= '0;
      r_min   <= '0;
    end else if (w_do_clear) begin
      r_presc <= '0;
      r_sec   <= '0;
      r_min   <= '0;
    end else if (r_state == S_RUN) begin
      if (w_tick) begin
        r_presc <= '0;
        if (r_sec == MAX_CNT) begin
          r_sec <= '0;
          r_min <= (r_min == MAX_CNT) ? '0 : r_min + CW'(1);
        end else begin
          r_sec <= r_sec + CW'(1);
        end
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end else if (r_state == S_IDLE) begin
      r_presc <= '0;
    end
  end

  // Registered status and pulse outputs
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_count_up_hr  <= 1'b0;
      r_rst_counters <= 1'b0;
      r_running      <= 1'b0;
    end else begin
      r_count_up_hr  <= w_tick && (r_sec == MAX_CNT) && (r_min == MAX_CNT);
      r_rst_counters <= w_do_clear;
      r_running      <= (w_state_nxt == S_RUN);
    end
  end

`ifdef STP_LAP_CAPTURE_EN
  logic          r_lap_q;
  logic [CW-1:0] r_lap_sec;
  logic [CW-1:0] r_lap_min;
  logic          r_lap_valid;
  logic          w_lap_ev;

  assign w_lap_ev  = btn_lap & ~r_lap_q;
  assign lap_sec   = r_lap_sec;
  assign lap_min   = r_lap_min;
  assign lap_valid = r_lap_valid;

  // Lap capture: latch the live count on a lap event while running
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_lap_q     <= 1'b0;
      r_lap_sec   <= '0;
      r_lap_min   <= '0;
      r_lap_valid <= 1'b0;
    end else begin
      r_lap_q <= btn_lap;
      if (w_do_clear) begin
        r_lap_sec   <= '0;
        r_lap_min   <= '0;
        r_lap_valid <= 1'b0;
      end else if (w_lap_ev && (r_state == S_RUN)) begin
        r_lap_sec   <= r_sec;
        r_lap_min   <= r_min;
        r_lap_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stp_watch_ctrl.sv
// Testbench for stp_watch_ctrl (TICK_DIV=4): directed stimulus pushes
// cycle-stamped expectations; a monitor pops and compares them at negedge.
// Lap checks are active when STP_LAP_CAPTURE_EN is defined.
module tb_stp_watch_ctrl;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       b_ss;
  logic       b_clr;
  logic [5:0] sec;
  logic [5:0] min;
  logic       count_up_hr;
  logic       rst_counters;
  logic       running;
`ifdef STP_LAP_CAPTURE_EN
  logic       b_lap;
  logic [5:0] lap_sec;
  logic [5:0] lap_min;
  logic       lap_valid;
`endif

  stp_watch_ctrl #(.TICK_DIV(4)) dut (
    .CLK            (CLK),
    .rst_n          (rst_n),
    .btn_start_stop (b_ss),
    .btn_clear      (b_clr),
    .sec            (sec),
    .min            (min),
    .count_up_hr    (count_up_hr),
    .rst_counters   (rst_counters),
    .running        (running)
`ifdef STP_LAP_CAPTURE_EN
    ,
    .btn_lap        (b_lap),
    .lap_sec        (lap_sec),
    .lap_min        (lap_min),
    .lap_valid      (lap_valid)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int    due;
    string nm;
    int    s;
    int    m;
    bit    r;
    int    cu;
    int    rc;
    bit    cl;
    int    ls;
    int    lm;
    bit    lv;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   cuh_cnt = 0;
  int   rc_cnt = 0;

  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
  end

  task automatic push(input int due, input string nm, input int s, input int m,
                      input bit r, input int cu, input int rc);
    exp_t e;
    e.due = due; e.nm = nm; e.s = s; e.m = m; e.r = r; e.cu = cu; e.rc = rc;
    e.cl = 1'b0; e.ls = 0; e.lm = 0; e.lv = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_lap(input int due, input string nm, input int s, input int m,
                          input bit r, input int cu, input int rc,
                          input int ls, input int lm, input bit lv);
    exp_t e;
    e.due = due; e.nm = nm; e.s = s; e.m = m; e.r = r; e.cu = cu; e.rc = rc;
    e.cl = 1'b1; e.ls = ls; e.lm = lm; e.lv = lv;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  // Monitor: count output pulses, then compare every expectation now due
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge CLK);
      if (count_up_hr === 1'b1) cuh_cnt = cuh_cnt + 1;
      if (rst_counters === 1'b1) rc_cnt = rc_cnt + 1;
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        ok = (int'(sec) == e.s) && (int'(min) == e.m) && (running === e.r) &&
             (cuh_cnt == e.cu) && (rc_cnt == e.rc);
`ifdef STP_LAP_CAPTURE_EN
        if (e.cl)
          ok = ok && (int'(lap_sec) == e.ls) && (int'(lap_min) == e.lm) &&
               (lap_valid === e.lv);
`endif
        total = total + 1;
        if (!ok) begin
          bad = bad + 1;
          $display("FAIL %s @cyc%0d: got sec=%0d min=%0d run=%0b hr_pulses=%0d clr_pulses=%0d, want sec=%0d min=%0d run=%0b hr_pulses=%0d clr_pulses=%0d",
                   e.nm, cyc, sec, min, running, cuh_cnt, rc_cnt,
                   e.s, e.m, e.r, e.cu, e.rc);
        end
      end
    end
  end

  // Watchdog
  initial begin
    wait (cyc >= 20000);
    $display("FAIL watchdog: cyc=%0d, limit 20000", cyc);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    rst_n = 1'b0; b_ss = 1'b0; b_clr = 1'b0;
`ifdef STP_LAP_CAPTURE_EN
    b_lap = 1'b0;
`endif
    push(2, "reset_state", 0, 0, 0, 0, 0);
    wait_to(3);
    rst_n = 1'b1;

    // start, three ticks after 12 cycles
    b_ss = 1'b1;
    push(15, "run_pre_tick3", 2, 0, 1, 0, 0);
    push(16, "run_12cyc", 3, 0, 1, 0, 0);
    wait_to(4);  b_ss = 1'b0;

    // clear in RUN ignored
    push(20, "clear_in_run_ignored", 4, 0, 1, 0, 0);
    wait_to(16); b_clr = 1'b1;
    wait_to(17); b_clr = 1'b0;

    // pause holds sec and prescaler; resume continues prescaler
    wait_to(20); b_ss = 1'b1;
    push(21, "pause_enter", 4, 0, 0, 0, 0);
    push(41, "pause_hold", 4, 0, 0, 0, 0);
    wait_to(21); b_ss = 1'b0;
    wait_to(41); b_ss = 1'b1;
    push(44, "resume_pre_tick", 4, 0, 1, 0, 0);
    push(45, "resume_tick", 5, 0, 1, 0, 0);
    wait_to(42); b_ss = 1'b0;

    // start+clear in PAUSE: clear wins, one rst_counters pulse
    wait_to(45); b_ss = 1'b1;
    wait_to(46); b_ss = 1'b0;
    push(48, "start_clear_pause", 0, 0, 0, 0, 1);
    push(49, "rst_counters_once", 0, 0, 0, 0, 1);
    push(53, "idle_hold", 0, 0, 0, 0, 1);
    wait_to(47); b_ss = 1'b1; b_clr = 1'b1;
    wait_to(48); b_ss = 1'b0; b_clr = 1'b0;

    // start+clear in RUN: start wins, clear dropped
    wait_to(53); b_ss = 1'b1;
    wait_to(54); b_ss = 1'b0;
    push(58, "start_wins_in_run", 0, 0, 0, 0, 1);
    wait_to(56); b_ss = 1'b1; b_clr = 1'b1;
    wait_to(57); b_ss = 1'b0; b_clr = 1'b0;

    // clear in PAUSE zeroes the prescaler: first tick 4 cycles after restart
    push(59, "clear_in_pause", 0, 0, 0, 0, 2);
    push(63, "presc_zeroed_pre", 0, 0, 1, 0, 2);
    push(64, "presc_zeroed_tick", 1, 0, 1, 0, 2);
    wait_to(58); b_clr = 1'b1;
    wait_to(59); b_clr = 1'b0; b_ss = 1'b1;
    wait_to(60); b_ss = 1'b0;

    // back to IDLE, then hold start for 50 cycles: one transition only
    wait_to(64); b_ss = 1'b1;
    wait_to(65); b_ss = 1'b0; b_clr = 1'b1;
    push(67, "held_start_run", 0, 0, 1, 0, 3);
    push(91, "held_start_mid", 6, 0, 1, 0, 3);
    push(116, "held_start_end", 12, 0, 1, 0, 3);
    wait_to(66); b_clr = 1'b0; b_ss = 1'b1;
    wait_to(116); b_ss = 1'b0;

    // run through minute carry and the 59:59 wrap
    push(306, "min_carry_pre", 59, 0, 1, 0, 3);
    push(307, "min_carry", 0, 1, 1, 0, 3);
    push(14459, "at_59_58", 58, 59, 1, 0, 3);
    push(14466, "at_59_59", 59, 59, 1, 0, 3);
    push(14467, "wrap_00_00", 0, 0, 1, 1, 3);
    push(14468, "hr_pulse_once", 0, 0, 1, 1, 3);
    push(14471, "after_wrap_tick", 1, 0, 1, 1, 3);
    wait_to(14471);

    // async reset mid-RUN: counts dropped, no rst_counters pulse
    #2 rst_n = 1'b0;
    push(14472, "reset_mid_run", 0, 0, 0, 1, 3);
    push(14476, "idle_after_reset", 0, 0, 0, 1, 3);
    wait_to(14473); rst_n = 1'b1;

    // button held through reset release yields one event
    wait_to(14477); rst_n = 1'b0; b_ss = 1'b1;
    push(14480, "btn_through_reset", 0, 0, 1, 1, 3);
    wait_to(14479); rst_n = 1'b1;
    wait_to(14481); b_ss = 1'b0;

    // lap capture, clear in PAUSE, lap outside RUN
    push_lap(14502, "lap_capture", 5, 0, 1, 1, 3, 5, 0, 1'b1);
    push_lap(14505, "lap_held", 6, 0, 1, 1, 3, 5, 0, 1'b1);
    push_lap(14507, "lap_cleared", 0, 0, 0, 1, 4, 0, 0, 1'b0);
    push_lap(14509, "lap_outside_run", 0, 0, 0, 1, 4, 0, 0, 1'b0);
`ifdef STP_LAP_CAPTURE_EN
    wait_to(14501); b_lap = 1'b1;
    wait_to(14502); b_lap = 1'b0;
`endif
    wait_to(14505); b_ss = 1'b1;
    wait_to(14506); b_ss = 1'b0; b_clr = 1'b1;
    wait_to(14507); b_clr = 1'b0;
`ifdef STP_LAP_CAPTURE_EN
    b_lap = 1'b1;
    wait_to(14508); b_lap = 1'b0;
`endif

    wait_to(14512);
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL scoreboard_drain: pending=%0d, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
